// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit: states,
// opcode/funct values, ALU operations and the datapath mux select codes.
package control_pkg;

  // Memory is word-addressed, so the FETCH increment is a single word.
  localparam int unsigned PC_STEP = 1;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL_LINK = 4'd12,
    S_JAL_WB   = 4'd13,
    S_JR       = 4'd14,
    S_UNUSED   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR  = 6'h08;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [5:0] ALU_PASSA = 6'h00;
  localparam logic [5:0] ALU_ADD   = 6'h20;
  localparam logic [5:0] ALU_SUB   = 6'h22;
  localparam logic [5:0] ALU_XOR   = 6'h26;
  localparam logic [5:0] ALU_SLT   = 6'h2A;

  localparam logic       MEM_IN_ALU = 1'b0;
  localparam logic       MEM_IN_PC  = 1'b1;
  localparam logic       REG_IN_ALU = 1'b0;
  localparam logic       REG_IN_MDR = 1'b1;
  localparam logic [1:0] DST_RT     = 2'd0;
  localparam logic [1:0] DST_RD     = 2'd1;
  localparam logic [1:0] DST_R31    = 2'd2;
  localparam logic       SRCA_A     = 1'b0;
  localparam logic       SRCA_PC    = 1'b1;
  localparam logic [1:0] SRCB_ONE   = 2'd0;
  localparam logic [1:0] SRCB_B     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMM2  = 2'd3;
  localparam logic [1:0] PCSRC_JUMP   = 2'd0;
  localparam logic [1:0] PCSRC_ALU    = 2'd1;
  localparam logic [1:0] PCSRC_ALURES = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic       mem_in;
    logic       mem_we;
    logic       ir_we;
    logic       a_we;
    logic       b_we;
    logic       reg_we;
    logic       reg_in;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] pc_src;
    logic [1:0] dst;
    logic [5:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // State following DECODE; FETCH marks an unsupported opcode/funct.
  function automatic state_e decode_next(input logic [5:0] op,
                                         input logic [5:0] funct);
    state_e nxt;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_SUB, FUNCT_SLT, FUNCT_XOR: nxt = S_EXEC_R;
          FUNCT_JR:                                   nxt = S_JR;
          default:                                    nxt = S_FETCH;
        endcase
      end
      OP_LW, OP_SW:     nxt = S_MEM_ADDR;
      OP_ADDI, OP_XORI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:   nxt = S_BRANCH;
      OP_J:             nxt = S_JUMP;
      OP_JAL:           nxt = S_JAL_LINK;
      default:          nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle: IR fields and zero flag in, enables/selects out.
interface multicycle_control_if;
  logic       zeroflag;
  logic [5:0] instr;
  logic [5:0] IR_ALU_OP;
  logic       PC_WE;
  logic       MEM_IN;
  logic       MEM_WE;
  logic       IR_WE;
  logic       A_WE;
  logic       B_WE;
  logic       REG_WE;
  logic       REG_IN;
  logic       ALU_SRCA;
  logic [1:0] ALU_SRCB;
  logic [1:0] PC_SRC;
  logic [1:0] DST;
  logic [5:0] ALU_OP;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  zeroflag, instr, IR_ALU_OP,
    output PC_WE, MEM_IN, MEM_WE, IR_WE, A_WE, B_WE, REG_WE, REG_IN,
           ALU_SRCA, ALU_SRCB, PC_SRC, DST, ALU_OP, illegal, state
  );

  modport slave (
    output zeroflag, instr, IR_ALU_OP,
    input  PC_WE, MEM_IN, MEM_WE, IR_WE, A_WE, B_WE, REG_WE, REG_IN,
           ALU_SRCA, ALU_SRCB, PC_SRC, DST, ALU_OP, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and
// combinational output decode driving every datapath enable and select.
module multicycle_control
  import control_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: a default assignment before the case keeps this purely
  // combinational; a path that skips the assignment would infer a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(bus.instr, bus.IR_ALU_OP);
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (bus.instr == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_JAL_LINK: state_d = S_JAL_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_in   = MEM_IN_PC;
        ctrl.ir_we    = 1'b1;
        ctrl.alu_srca = SRCA_PC;
        ctrl.alu_srcb = SRCB_ONE;
        ctrl.pc_src   = PCSRC_ALU;
        ctrl.pc_we    = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_srca = SRCA_PC;
        ctrl.alu_srcb = SRCB_IMM;
        // An unsupported instruction aborts with no register-file side effects.
        if (decode_next(bus.instr, bus.IR_ALU_OP) == S_FETCH) begin
          ctrl.illegal = 1'b1;
        end else begin
          ctrl.a_we = 1'b1;
          ctrl.b_we = 1'b1;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_srca = SRCA_A;
        ctrl.alu_srcb = SRCB_B;
        ctrl.alu_op   = bus.IR_ALU_OP;
      end
      S_R_WB: begin
        ctrl.reg_in = REG_IN_ALU;
        ctrl.dst    = DST_RD;
        ctrl.reg_we = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_srca = SRCA_A;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.alu_op   = (bus.instr == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_I_WB: begin
        ctrl.reg_in = REG_IN_ALU;
        ctrl.dst    = DST_RT;
        ctrl.reg_we = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_srca = SRCA_A;
        ctrl.alu_srcb = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_in = MEM_IN_ALU;
      end
      S_MEM_WB: begin
        ctrl.reg_in = REG_IN_MDR;
        ctrl.dst    = DST_RT;
        ctrl.reg_we = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_in = MEM_IN_ALU;
        ctrl.mem_we = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_srca = SRCA_A;
        ctrl.alu_srcb = SRCB_B;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_src   = PCSRC_ALURES;
        ctrl.pc_we    = (bus.instr == OP_BEQ) ? bus.zeroflag : ~bus.zeroflag;
      end
      S_JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_we  = 1'b1;
      end
      S_JAL_LINK: begin
        ctrl.alu_srca = SRCA_PC;
        ctrl.alu_op   = ALU_PASSA;
      end
      S_JAL_WB: begin
        ctrl.reg_in = REG_IN_ALU;
        ctrl.dst    = DST_R31;
        ctrl.reg_we = 1'b1;
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_we  = 1'b1;
      end
      S_JR: begin
        ctrl.alu_srca = SRCA_A;
        ctrl.alu_op   = ALU_PASSA;
        ctrl.pc_src   = PCSRC_ALU;
        ctrl.pc_we    = 1'b1;
      end
      default: ;
    endcase

    // Reset may land mid-instruction; suppress every state-changing write.
    if (reset) begin
      ctrl.pc_we   = 1'b0;
      ctrl.mem_we  = 1'b0;
      ctrl.ir_we   = 1'b0;
      ctrl.reg_we  = 1'b0;
      ctrl.a_we    = 1'b0;
      ctrl.b_we    = 1'b0;
      ctrl.illegal = 1'b0;
    end
  end

  assign bus.PC_WE    = ctrl.pc_we;
  assign bus.MEM_IN   = ctrl.mem_in;
  assign bus.MEM_WE   = ctrl.mem_we;
  assign bus.IR_WE    = ctrl.ir_we;
  assign bus.A_WE     = ctrl.a_we;
  assign bus.B_WE     = ctrl.b_we;
  assign bus.REG_WE   = ctrl.reg_we;
  assign bus.REG_IN   = ctrl.reg_in;
  assign bus.ALU_SRCA = ctrl.alu_srca;
  assign bus.ALU_SRCB = ctrl.alu_srcb;
  assign bus.PC_SRC   = ctrl.pc_src;
  assign bus.DST      = ctrl.dst;
  assign bus.ALU_OP   = ctrl.alu_op;
  assign bus.illegal  = ctrl.illegal;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares outputs against hand-computed values.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Must be called while in FETCH; loads the IR fields and moves to DECODE.
  task automatic start(input string tag, input logic [5:0] op,
                       input logic [5:0] funct);
    check({tag, " fetch state"}, 32'(bus.state), 32'd0);
    bus.instr     = op;
    bus.IR_ALU_OP = funct;
    tick();
    check({tag, " decode state"}, 32'(bus.state), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.zeroflag  = 1'b0;
    bus.instr     = 6'h00;
    bus.IR_ALU_OP = 6'h20;
    tick();
    reset = 1'b0;
    #1;
    check("fetch ir_we", 32'(bus.IR_WE), 32'd1);
    check("fetch pc_we", 32'(bus.PC_WE), 32'd1);
    check("fetch mem_in", 32'(bus.MEM_IN), 32'd1);
    check("fetch srca/srcb/pcsrc",
          {27'd0, bus.ALU_SRCA, bus.ALU_SRCB, bus.PC_SRC}, {27'd0, 1'b1, 2'd0, 2'd1});
    check("fetch alu_op", 32'(bus.ALU_OP), 32'h20);
    tick();
    check("add decode state", 32'(bus.state), 32'd1);
    check("decode a/b_we", {30'd0, bus.A_WE, bus.B_WE}, 32'd3);
    check("decode srcb", 32'(bus.ALU_SRCB), 32'd2);
    tick();
    check("add exec_r state", 32'(bus.state), 32'd2);

    // Reset held two cycles starting in EXEC_R.
    reset = 1'b1;
    tick();
    check("rst1 state", 32'(bus.state), 32'd0);
    check("rst1 enables",
          {25'd0, bus.PC_WE, bus.MEM_WE, bus.IR_WE, bus.REG_WE, bus.A_WE, bus.B_WE, bus.illegal},
          32'd0);
    tick();
    check("rst2 state", 32'(bus.state), 32'd0);
    check("rst2 ir_we", 32'(bus.IR_WE), 32'd0);
    check("rst2 pc_we", 32'(bus.PC_WE), 32'd0);
    reset = 1'b0;
    #1;

    // LW: 0,1,6,7,8,0
    start("lw", 6'h23, 6'h00);
    tick(); check("lw state6", 32'(bus.state), 32'd6);
    check("lw addr srcb", 32'(bus.ALU_SRCB), 32'd2);
    tick(); check("lw state7", 32'(bus.state), 32'd7);
    check("lw rd mem_in/we/regwe", {29'd0, bus.MEM_IN, bus.MEM_WE, bus.REG_WE}, 32'd0);
    tick(); check("lw state8", 32'(bus.state), 32'd8);
    check("lw wb reg_we/reg_in", {30'd0, bus.REG_WE, bus.REG_IN}, 32'd3);
    check("lw wb dst", 32'(bus.DST), 32'd0);
    check("lw wb mem_we", 32'(bus.MEM_WE), 32'd0);
    tick(); check("lw back to fetch", 32'(bus.state), 32'd0);

    // SW: 0,1,6,9,0
    start("sw", 6'h2B, 6'h00);
    tick(); check("sw state6", 32'(bus.state), 32'd6);
    check("sw addr mem_we", 32'(bus.MEM_WE), 32'd0);
    tick(); check("sw state9", 32'(bus.state), 32'd9);
    check("sw mem_we/mem_in", {30'd0, bus.MEM_WE, bus.MEM_IN}, 32'd2);
    check("sw reg_we", 32'(bus.REG_WE), 32'd0);
    tick(); check("sw back to fetch", 32'(bus.state), 32'd0);

    // BEQ then BNE, each with zeroflag=1 and then 0.
    start("beq", 6'h04, 6'h00);
    tick(); check("beq state", 32'(bus.state), 32'd10);
    bus.zeroflag = 1'b1; #1;
    check("beq z1 pc_we", 32'(bus.PC_WE), 32'd1);
    check("beq pc_src", 32'(bus.PC_SRC), 32'd2);
    check("beq alu_op", 32'(bus.ALU_OP), 32'h22);
    bus.zeroflag = 1'b0; #1;
    check("beq z0 pc_we", 32'(bus.PC_WE), 32'd0);
    tick(); check("beq back to fetch", 32'(bus.state), 32'd0);
    start("bne", 6'h05, 6'h00);
    tick(); check("bne state", 32'(bus.state), 32'd10);
    bus.zeroflag = 1'b1; #1;
    check("bne z1 pc_we", 32'(bus.PC_WE), 32'd0);
    bus.zeroflag = 1'b0; #1;
    check("bne z0 pc_we", 32'(bus.PC_WE), 32'd1);
    tick(); check("bne back to fetch", 32'(bus.state), 32'd0);

    // R-type SLT
    start("slt", 6'h00, 6'h2A);
    tick(); check("slt exec state", 32'(bus.state), 32'd2);
    check("slt alu_op", 32'(bus.ALU_OP), 32'h2A);
    check("slt srca/srcb", {29'd0, bus.ALU_SRCA, bus.ALU_SRCB}, {29'd0, 1'b0, 2'd1});
    tick(); check("slt wb state", 32'(bus.state), 32'd3);
    check("slt wb reg_we/dst", {29'd0, bus.REG_WE, bus.DST}, {29'd0, 1'b1, 2'd1});
    tick(); check("slt back to fetch", 32'(bus.state), 32'd0);

    // XORI
    start("xori", 6'h0E, 6'h00);
    tick(); check("xori state", 32'(bus.state), 32'd4);
    check("xori alu_op", 32'(bus.ALU_OP), 32'h26);
    tick(); check("xori wb state", 32'(bus.state), 32'd5);
    check("xori wb reg_we/dst", {29'd0, bus.REG_WE, bus.DST}, {29'd0, 1'b1, 2'd0});
    tick(); check("xori back to fetch", 32'(bus.state), 32'd0);

    // JAL
    start("jal", 6'h03, 6'h00);
    tick(); check("jal link state", 32'(bus.state), 32'd12);
    check("jal link alu_op", 32'(bus.ALU_OP), 32'h00);
    check("jal link srca/pc_we", {30'd0, bus.ALU_SRCA, bus.PC_WE}, 32'd2);
    tick(); check("jal wb state", 32'(bus.state), 32'd13);
    check("jal wb dst", 32'(bus.DST), 32'd2);
    check("jal wb reg_we/pc_we", {30'd0, bus.REG_WE, bus.PC_WE}, 32'd3);
    check("jal wb pc_src", 32'(bus.PC_SRC), 32'd0);
    tick(); check("jal back to fetch", 32'(bus.state), 32'd0);

    // J and JR
    start("j", 6'h02, 6'h00);
    tick(); check("j state", 32'(bus.state), 32'd11);
    check("j pc_we/pc_src", {29'd0, bus.PC_WE, bus.PC_SRC}, {29'd0, 1'b1, 2'd0});
    tick(); check("j back to fetch", 32'(bus.state), 32'd0);
    start("jr", 6'h00, 6'h08);
    tick(); check("jr state", 32'(bus.state), 32'd14);
    check("jr pc_we/pc_src", {29'd0, bus.PC_WE, bus.PC_SRC}, {29'd0, 1'b1, 2'd1});
    check("jr alu_op", 32'(bus.ALU_OP), 32'h00);
    tick(); check("jr back to fetch", 32'(bus.state), 32'd0);

    // Illegal opcode and illegal R-type funct
    start("ill op", 6'h3F, 6'h00);
    check("ill op illegal", 32'(bus.illegal), 32'd1);
    check("ill op writes", {29'd0, bus.REG_WE, bus.MEM_WE, bus.PC_WE}, 32'd0);
    tick(); check("ill op next state", 32'(bus.state), 32'd0);
    check("ill op cleared", 32'(bus.illegal), 32'd0);
    start("ill funct", 6'h00, 6'h3F);
    check("ill funct illegal", 32'(bus.illegal), 32'd1);
    tick(); check("ill funct next state", 32'(bus.state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
